pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Handles three cases: load-use hazards, taken-branch flushes resolved in ID, and
//  multi-cycle data-memory waits. Drives the write/flush/hold controls of PC,
//  IF/ID, ID/EX, EX/MEM and MEM/WB. Tracks stall cycles and a memory-timeout error.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive MEM_WAIT cycles before entering ERR (>=1)
//  CNT_W        16  width of stall_cycles performance counter
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      synchronous, active-high reset
//  id_rs           in   5      rs field of instruction in ID
//  id_rt           in   5      rt field of instruction in ID
//  id_uses_rt      in   1      ID instruction reads rt
//  id_branch_taken in   1      branch in ID resolved taken
//  ex_mem_read     in   1      instruction in EX is a load
//  ex_dest         in   5      destination reg of instruction in EX
//  mem_access      in   1      instruction in MEM is a load/store
//  dmem_ready      in   1      data memory completes access this cycle
//  pc_write        out  1      1 = PC may update
//  ifid_write      out  1      1 = IF/ID may load
//  ifid_flush      out  1      1 = IF/ID loads NOP
//  idex_flush      out  1      1 = ID/EX loads bubble (all control 0)
//  exmem_hold      out  1      1 = EX/MEM keeps contents
//  memwb_bubble    out  1      1 = MEM/WB loads writeBack=0, memRead=0
//  busy            out  1      1 = state is MEM_WAIT
//  err             out  1      sticky memory-timeout flag
//  stall_cycles    out  CNT_W  count of cycles with pc_write=0 (saturating)
// BEHAVIOUR
//  - Control outputs are combinational (Mealy) on state and inputs, so they act in
//    the same cycle. state, wait_cnt, err and stall_cycles are registered.
//  - While rst=1, all outputs are 0. On the next edge: state=RUN, wait_cnt=0,
//    err=0, stall_cycles=0. Reset in MEM_WAIT or ERR returns to RUN.
//  - States: RUN, MEM_WAIT, ERR.
//  - memstall = mem_access & ~dmem_ready.
//  - loaduse = ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
//  - Default (no event): pc_write=1, ifid_write=1, all flush/hold/bubble=0.
//  - Priority per cycle: ERR > memstall > loaduse > id_branch_taken.
//  - memstall (in RUN or MEM_WAIT): pc_write=0, ifid_write=0, exmem_hold=1,
//    memwb_bubble=1, flushes=0. RUN->MEM_WAIT; wait_cnt increments each stalled cycle.
//  - MEM_WAIT with dmem_ready=1: release in the same cycle (default outputs, with
//    loaduse/branch rules applied). Go to RUN; wait_cnt=0.
//  - MEM_WAIT with wait_cnt==MEM_TIMEOUT-1 and still stalled: go to ERR next cycle.
//  - ERR: freeze outputs as for memstall. err=1 until rst. dmem_ready is ignored.
//  - loaduse (no memstall): pc_write=0, ifid_write=0, idex_flush=1 for one cycle.
//    Any branch in ID is ignored that cycle (stale operands).
//  - id_branch_taken (no higher event): ifid_flush=1, pc_write=1, ifid_write=1.
//  - A loaduse or branch arriving during MEM_WAIT is not acted on. It is evaluated
//    in the release cycle, since frozen stages hold their inputs.
//  - stall_cycles += 1 on every edge where pc_write=0 and rst=0; holds at 2^CNT_W-1.
//  - A load to $0 never stalls.
// TESTING
//  1 load-use: ex_mem_read=1, ex_dest=5, id_rs=5 -> 1 cycle with pc_write=0,
//    idex_flush=1; stall_cycles=1; next cycle defaults.
//  2 no hazard: ex_dest=5, id_rt=5, id_uses_rt=0 -> pc_write=1, no flush. ex_dest=0,
//    id_rs=0 -> no stall.
//  3 mem wait: mem_access=1, dmem_ready=0 for 3 cycles, then 1 -> busy=1 for 3
//    cycles, exmem_hold/memwb_bubble=1, release on ready cycle; stall_cycles=3.
//  4 timeout: dmem_ready held 0 with MEM_TIMEOUT=4 -> ERR after 4 stalled cycles,
//    err=1, outputs frozen; rst -> RUN, err=0, stall_cycles=0.
//  5 simultaneous: memstall + id_branch_taken -> freeze, no ifid_flush; on release
//    cycle ifid_flush=1. loaduse + id_branch_taken -> load-use stall only.
//  6 reset mid-MEM_WAIT (wait_cnt=2): assert rst -> all outputs 0; state RUN,
//    wait_cnt=0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for a 5-stage pipeline (IF/ID/EX/MEM/WB).
// Resolves load-use hazards, taken-branch flushes resolved in ID and
// multi-cycle data-memory waits. It also keeps a saturating count of stalled
// cycles and a sticky memory-timeout error.
//
// Ports
//   clk               in   clock, rising edge
//   rst               in   synchronous, active-high reset
//   i_id_rs/i_id_rt   in   source register fields of the instruction in ID
//   i_id_uses_rt      in   ID instruction reads rt
//   i_id_branch_taken in   branch in ID resolved taken
//   i_ex_mem_read     in   instruction in EX is a load
//   i_ex_dest         in   destination register of the instruction in EX
//   i_mem_access      in   instruction in MEM is a load/store
//   i_dmem_ready      in   data memory completes its access this cycle
//   o_pc_write        out  PC may update
//   o_ifid_write      out  IF/ID may load
//   o_ifid_flush      out  IF/ID loads a NOP
//   o_idex_flush      out  ID/EX loads a bubble
//   o_exmem_hold      out  EX/MEM keeps its contents
//   o_memwb_bubble    out  MEM/WB loads writeBack=0, memRead=0
//   o_busy            out  controller is waiting on data memory
//   o_err             out  sticky memory-timeout flag
//   o_stall_cycles    out  saturating count of cycles with pc_write=0
// The control outputs are combinational on state and inputs, so they act in
// the same cycle. All outputs are forced to 0 while rst is high.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_branch_taken,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_ex_dest,
    input  logic             i_mem_access,
    input  logic             i_dmem_ready,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_hold,
    output logic             o_memwb_bubble,
    output logic             o_busy,
    output logic             o_err,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    // wait_cnt only ever holds 0 .. MEM_TIMEOUT-1
    localparam int               WC_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_next;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [WC_W-1:0]   w_wait_next;
    logic              r_err;
    logic              w_err_next;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic w_memstall;
    logic w_loaduse;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_hold;
    logic w_memwb_bubble;
    logic w_busy;

    // A load targeting $0 never produces a hazard
    assign w_memstall = i_mem_access & ~i_dmem_ready;
    assign w_loaduse  = i_ex_mem_read & (i_ex_dest != 5'd0) &
                        ((i_ex_dest == i_id_rs) | (i_id_uses_rt & (i_ex_dest == i_id_rt)));

    // Next-state and Mealy control outputs; priority ERR > memstall > loaduse > branch
    always_comb begin
        w_state_next   = r_state;
        w_wait_next    = r_wait_cnt;
        w_err_next     = r_err;
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_hold   = 1'b0;
        w_memwb_bubble = 1'b0;
        w_busy         = (r_state == ST_MEM_WAIT);
        case (r_state)
            ST_ERR: begin
                // Frozen until reset; dmem_ready is deliberately ignored
                w_pc_write     = 1'b0;
                w_ifid_write   = 1'b0;
                w_exmem_hold   = 1'b1;
                w_memwb_bubble = 1'b1;
                w_err_next     = 1'b1;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (w_memstall) begin
                    w_pc_write     = 1'b0;
                    w_ifid_write   = 1'b0;
                    w_exmem_hold   = 1'b1;
                    w_memwb_bubble = 1'b1;
                    // wait_cnt is 0 in RUN, so MEM_TIMEOUT=1 errors on the first stall
                    if (r_wait_cnt == WC_LAST) begin
                        w_state_next = ST_ERR;
                        w_wait_next  = {WC_W{1'b0}};
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next = ST_MEM_WAIT;
                        w_wait_next  = r_wait_cnt + WC_W'(1);
                    end
                end else begin
                    // Release (or normal run): frozen ID inputs are evaluated now
                    w_state_next = ST_RUN;
                    w_wait_next  = {WC_W{1'b0}};
                    if (w_loaduse) begin
                        // Branch operands are stale, so a taken branch is ignored
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_idex_flush = 1'b1;
                    end else if (i_id_branch_taken) begin
                        w_ifid_flush = 1'b1;
                    end else begin
                        w_ifid_flush = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next   = ST_RUN;
                w_wait_next    = {WC_W{1'b0}};
                w_pc_write     = 1'b0;
                w_ifid_write   = 1'b0;
                w_exmem_hold   = 1'b1;
                w_memwb_bubble = 1'b1;
                w_busy         = 1'b0;
            end
        endcase
        if (rst) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_ifid_flush   = 1'b0;
            w_idex_flush   = 1'b0;
            w_exmem_hold   = 1'b0;
            w_memwb_bubble = 1'b0;
            w_busy         = 1'b0;
        end else begin
            w_busy = w_busy;
        end
    end

    // State, wait counter and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= {WC_W{1'b0}};
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            r_err      <= w_err_next;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= {CNT_W{1'b0}};
        end else if (!w_pc_write && (r_stall_cycles != CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign o_pc_write     = w_pc_write;
    assign o_ifid_write   = w_ifid_write;
    assign o_ifid_flush   = w_ifid_flush;
    assign o_idex_flush   = w_idex_flush;
    assign o_exmem_hold   = w_exmem_hold;
    assign o_memwb_bubble = w_memwb_bubble;
    assign o_busy         = w_busy;
    assign o_err          = rst ? 1'b0 : r_err;
    assign o_stall_cycles = rst ? {CNT_W{1'b0}} : r_stall_cycles;

endmodule
